// File: rtl/conv_layer_job_scheduler_pkg.sv
// conv_sched_pkg: shared types and default constants for the convolution
// layer job scheduler.
//   sched_state_t : scheduler FSM states
//   DEF_EXP_ROWS  : default valid pulses per image (features x rows)
//   DEF_GAP_CYC   : default enable-low drain cycles between jobs
//   owner_id_t    : requester id, wide enough for the 8-requester maximum
package conv_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } sched_state_t;

   localparam int unsigned DEF_EXP_ROWS = 24;
   localparam int unsigned DEF_GAP_CYC  = 2;
   localparam int unsigned OWNER_MAX_W  = 3;

   typedef logic [OWNER_MAX_W-1:0] owner_id_t;

endpackage

// File: rtl/conv_layer_job_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over NUM_REQ requests.
// The search starts at last_grant+1 (mod NUM_REQ).
//   req        in   request vector
//   last_grant in   index of the most recently accepted requester
//   grant      out  one-hot winner (zero when no request)
//   grant_idx  out  encoded winner index
module rr_arbiter
   import conv_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic [IDX_W-1:0] cand;

   // Scan from the lowest priority candidate upward so the highest priority
   // hit is the last one written.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned k = NUM_REQ; k >= 1; k--) begin
         cand = IDX_W'((32'(last_grant) + k) % NUM_REQ);
         if (req[cand]) begin
            grant       = '0;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/conv_layer_job_scheduler.sv
// conv_layer_job_scheduler: shares one convolution layer between NUM_REQ
// job sources. Accepts one job at a time (round-robin), launches the layer at
// the job's base address, tags each valid row output with owner/feature/row,
// and retires the job on conv_image_fin after a GAP_CYC enable-low drain.
// Optional feature macro: CONV_SCHED_WATCHDOG_EN (RUN-state watchdog that
// forces a retire with err after TIMEOUT_CYC cycles without conv_valid).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_base/req_ready    job request handshake (req 0 in LSBs)
//   done/err                        one-cycle retire / error pulse to owner
//   busy, owner                     not-IDLE flag, current or last owner
//   conv_enable, conv_base_addr     layer launch controls
//   conv_valid, conv_feature_idx,
//   conv_feature_row, conv_image_fin  layer outputs
//   wr_en/wr_owner/wr_feat/wr_row   registered tagged write to feature buffer
module conv_layer_job_scheduler
   import conv_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned FEAT_W      = 3,
   parameter int unsigned ROW_W       = 3,
   parameter int unsigned EXP_ROWS    = DEF_EXP_ROWS,
   parameter int unsigned GAP_CYC     = DEF_GAP_CYC,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_base,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          done,
   output logic [NUM_REQ-1:0]          err,
   output logic                        busy,
   output logic [$clog2(NUM_REQ)-1:0]  owner,
   output logic                        conv_enable,
   output logic [ADDR_W-1:0]           conv_base_addr,
   input  logic                        conv_valid,
   input  logic [FEAT_W-1:0]           conv_feature_idx,
   input  logic [ROW_W-1:0]            conv_feature_row,
   input  logic                        conv_image_fin,
   output logic                        wr_en,
   output logic [$clog2(NUM_REQ)-1:0]  wr_owner,
   output logic [FEAT_W-1:0]           wr_feat,
   output logic [ROW_W-1:0]            wr_row
);

   localparam int unsigned OW    = $clog2(NUM_REQ);
   localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   sched_state_t       state, state_nx;
   logic [OW-1:0]      last_grant, grant_idx;
   logic [NUM_REQ-1:0] grant, owner_hot;
   logic [ADDR_W-1:0]  base_sel;
   logic [7:0]         row_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic               accept, run_valid, row_ok, wd_hit, wd_fired;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (OW)
   ) u_arb (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   assign req_ready = (state == S_IDLE) ? grant : '0;
   assign accept    = |(req_valid & req_ready);
   assign run_valid = (state == S_RUN) && conv_valid;
   assign busy      = (state != S_IDLE);
   assign owner_hot = NUM_REQ'(1) << owner;
   assign row_ok    = (row_cnt == 8'(EXP_ROWS));
   assign done      = (state == S_DONE) ? owner_hot : '0;
   assign err       = ((state == S_DONE) && (!row_ok || wd_fired)) ? owner_hot : '0;

   always_comb begin
      base_sel = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) base_sel = req_base[k*ADDR_W +: ADDR_W];
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = S_RUN;
         S_RUN:   if (conv_image_fin || wd_hit) state_nx = S_DRAIN;
         S_DRAIN: if (gap_cnt == GAP_W'(GAP_CYC - 1)) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant     <= OW'(NUM_REQ - 1);
         owner          <= '0;
         conv_base_addr <= '0;
         conv_enable    <= 1'b0;
         row_cnt        <= '0;
         gap_cnt        <= '0;
         wr_en          <= 1'b0;
         wr_owner       <= '0;
         wr_feat        <= '0;
         wr_row         <= '0;
      end else begin
         // Enable tracks the registered RUN state: set on accept, dropped
         // on the RUN->DRAIN edge.
         conv_enable <= (state_nx == S_RUN);
         gap_cnt     <= (state == S_DRAIN) ? gap_cnt + 1'b1 : '0;
         wr_en       <= run_valid;
         if (run_valid) begin
            wr_owner <= owner;
            wr_feat  <= conv_feature_idx;
            wr_row   <= conv_feature_row;
            if (row_cnt != '1) row_cnt <= row_cnt + 1'b1;
         end
         if (accept) begin
            last_grant     <= grant_idx;
            owner          <= grant_idx;
            conv_base_addr <= base_sel;
            row_cnt        <= '0;
         end
      end
   end

`ifdef CONV_SCHED_WATCHDOG_EN
   logic [12:0] wd_cnt;

   assign wd_hit = (state == S_RUN) && !conv_valid && (wd_cnt == 13'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt   <= '0;
         wd_fired <= 1'b0;
      end else if (accept) begin
         wd_cnt   <= '0;
         wd_fired <= 1'b0;
      end else if (state == S_RUN) begin
         wd_cnt <= conv_valid ? '0 : wd_cnt + 1'b1;
         if (wd_hit) wd_fired <= 1'b1;
      end
   end
`else
   assign wd_hit   = 1'b0;
   assign wd_fired = 1'b0;
`endif

endmodule

// File: tb/tb_conv_layer_job_scheduler.sv
// Self-checking bench for conv_layer_job_scheduler: randomized jobs against a
// round-robin reference model, with tag and retire expectations queued into a
// scoreboard popped by an independent negedge monitor.
module tb_conv_layer_job_scheduler;

   localparam int NREQ = 4;
   localparam int AW   = 16;
   localparam int EXP  = 24;
   localparam int GAP  = 2;
   localparam int TO   = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [63:0] req_base = '0;
   logic [3:0]  req_ready, done, err;
   logic        busy, conv_enable, wr_en;
   logic [1:0]  owner, wr_owner;
   logic [15:0] conv_base_addr;
   logic        conv_valid = 1'b0;
   logic        conv_image_fin = 1'b0;
   logic [2:0]  conv_feature_idx = '0;
   logic [2:0]  conv_feature_row = '0;
   logic [2:0]  wr_feat, wr_row;

   int errors = 0;
   int checks = 0;
   int model_lg = NREQ - 1;

   typedef struct {int owner; int feat; int row;} tag_t;
   typedef struct {int owner; bit err;} fin_t;
   tag_t exp_tags[$];
   fin_t exp_fins[$];

   always #5 clk = ~clk;

   conv_layer_job_scheduler #(
      .NUM_REQ     (NREQ),
      .ADDR_W      (AW),
      .FEAT_W      (3),
      .ROW_W       (3),
      .EXP_ROWS    (EXP),
      .GAP_CYC     (GAP),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_base         (req_base),
      .req_ready        (req_ready),
      .done             (done),
      .err              (err),
      .busy             (busy),
      .owner            (owner),
      .conv_enable      (conv_enable),
      .conv_base_addr   (conv_base_addr),
      .conv_valid       (conv_valid),
      .conv_feature_idx (conv_feature_idx),
      .conv_feature_row (conv_feature_row),
      .conv_image_fin   (conv_image_fin),
      .wr_en            (wr_en),
      .wr_owner         (wr_owner),
      .wr_feat          (wr_feat),
      .wr_row           (wr_row)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbitration: first requester after the last grant, wrapping.
   function automatic int model_pick(input logic [3:0] m, input int lg);
      int c;
      for (int k = 1; k <= NREQ; k++) begin
         c = (lg + k) % NREQ;
         if (m[c[1:0]]) return c;
      end
      return -1;
   endfunction

   // Scoreboard monitor.
   always @(negedge clk) begin
      tag_t t;
      fin_t f;
      if (wr_en) begin
         if (exp_tags.size() == 0) chk("unexpected_tag", 32'(wr_en), 0);
         else begin
            t = exp_tags.pop_front();
            chk("tag_owner", 32'(wr_owner), t.owner);
            chk("tag_feat", 32'(wr_feat), t.feat);
            chk("tag_row", 32'(wr_row), t.row);
         end
      end
      if ((|done) || (|err)) begin
         if (exp_fins.size() == 0) chk("unexpected_done", 32'(done), 0);
         else begin
            f = exp_fins.pop_front();
            chk("done_vec", 32'(done), 1 << f.owner);
            chk("err_vec", 32'(err), f.err ? (1 << f.owner) : 0);
         end
      end
      if (busy) chk("ready_when_busy", 32'(req_ready), 0);
   end

   task automatic do_accept(input logic [3:0] mask, input logic [63:0] bases,
                            input bit hold, output int g);
      int k;
      req_base  = bases;
      req_valid = mask;
      k = 0;
      @(negedge clk);
      while (busy && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("idle_reached", 32'(busy), 0);
      g = model_pick(mask, model_lg);
      chk("req_ready", 32'(req_ready), 1 << g);
      @(posedge clk); #1;
      model_lg = g;
      if (!hold) req_valid = '0;
      chk("owner", 32'(owner), g);
      chk("base_addr", 32'(conv_base_addr), 32'(bases[g*16 +: 16]));
      chk("enable_on", 32'(conv_enable), 1);
      chk("busy_on", 32'(busy), 1);
   endtask

   task automatic do_rows(input int g, input int nrows, input bit same_cycle);
      tag_t t;
      for (int i = 0; i < nrows; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         conv_feature_idx = 3'($urandom_range(0, 7));
         conv_feature_row = 3'($urandom_range(0, 7));
         t.owner = g; t.feat = conv_feature_idx; t.row = conv_feature_row;
         exp_tags.push_back(t);
         conv_valid = 1'b1;
         if (same_cycle && i == nrows - 1) conv_image_fin = 1'b1;
         @(posedge clk); #1;
         conv_valid     = 1'b0;
         conv_image_fin = 1'b0;
      end
   endtask

   // Waits for the retire pulse and returns the negedge index it appeared on.
   task automatic wait_done(input int limit, output int lat);
      lat = 0;
      for (int j = 1; j <= limit && lat == 0; j++) begin
         @(negedge clk);
         if (j == 2) conv_valid = 1'b0;
         if (|done) lat = j;
      end
      conv_valid = 1'b0;
   endtask

   task automatic run_job(input logic [3:0] mask, input logic [63:0] bases, input int nrows,
                          input bit same_cycle, input bit hold, output int g);
      fin_t f;
      int lat;
      do_accept(mask, bases, hold, g);
      f.owner = g; f.err = (nrows != EXP);
      exp_fins.push_back(f);
      do_rows(g, nrows, same_cycle);
      if (!same_cycle || nrows == 0) begin
         conv_image_fin = 1'b1;
         @(posedge clk); #1;
         conv_image_fin = 1'b0;
      end
      chk("enable_off_after_fin", 32'(conv_enable), 0);
      // A stray row strobe during DRAIN must be ignored.
      conv_feature_idx = 3'($urandom_range(0, 7));
      conv_valid = 1'b1;
      wait_done(10, lat);
      chk("done_latency", lat, GAP + 1);
      @(posedge clk); #1;
   endtask

   initial begin
      int g, lat, n;
      fin_t f;
      logic [63:0] b;
      int row_opts[4] = '{23, 24, 25, 0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_enable", 32'(conv_enable), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_base", 32'(conv_base_addr), 0);
      chk("rst_ready", 32'(req_ready), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single job: requester 2, base 0x0400, 24 rows.
      b = {$urandom, $urandom};
      b[47:32] = 16'h0400;
      run_job(4'b0100, b, 24, 1'b0, 1'b0, g);
      chk("single_owner", g, 2);
      // Row mismatch and same-cycle boundary.
      run_job(4'($urandom_range(1, 15)), {$urandom, $urandom}, 23, 1'b0, 1'b0, g);
      run_job(4'($urandom_range(1, 15)), {$urandom, $urandom}, 24, 1'b1, 1'b0, g);
      // Counter saturation: 280 rows must not wrap back to 24.
      run_job(4'($urandom_range(1, 15)), {$urandom, $urandom}, 280, 1'b0, 1'b0, g);
      // Random jobs.
      for (int i = 0; i < 6; i++) begin
         n = row_opts[$urandom_range(0, 3)];
         if (n == 0) n = $urandom_range(1, 30);
         run_job(4'($urandom_range(1, 15)), {$urandom, $urandom}, n,
                 1'($urandom_range(0, 1)), 1'b0, g);
      end

      // Reset in the middle of a job after 10 rows.
      do_accept(4'b1010, {$urandom, $urandom}, 1'b0, g);
      do_rows(g, 10, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_enable", 32'(conv_enable), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_wr_en", 32'(wr_en), 0);
      chk("midrst_done", 32'(done), 0);
      exp_tags.delete();
      model_lg = NREQ - 1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fairness with all four requests held high: order 0,1,2,3,0.
      for (int i = 0; i < 5; i++) begin
         run_job(4'hF, {$urandom, $urandom}, $urandom_range(20, 26), 1'b0, 1'b1, g);
         chk("fair_order", g, i % NREQ);
      end
      req_valid = '0;
      @(posedge clk); #1;

      // Stalled job with no row strobes.
      do_accept(4'($urandom_range(1, 15)), {$urandom, $urandom}, 1'b0, g);
      f.owner = g; f.err = 1'b1;
      exp_fins.push_back(f);
`ifdef CONV_SCHED_WATCHDOG_EN
      wait_done(200, lat);
      chk("wd_done_latency", lat, TO + GAP + 1);
      chk("wd_enable_off", 32'(conv_enable), 0);
      @(posedge clk); #1;
`else
      repeat (100) @(posedge clk);
      #1;
      chk("stall_busy", 32'(busy), 1);
      chk("stall_enable", 32'(conv_enable), 1);
      conv_image_fin = 1'b1;
      @(posedge clk); #1;
      conv_image_fin = 1'b0;
      wait_done(10, lat);
      chk("stall_done_latency", lat, GAP + 1);
      @(posedge clk); #1;
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("tags_left", exp_tags.size(), 0);
      chk("fins_left", exp_fins.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/conv_layer_job_scheduler.md
# conv_layer_job_scheduler

Round-robin scheduler that shares one convolution layer datapath (controller, input interface and kernel array behind a single `enable`) between up to NUM_REQ image-job requesters. It accepts one job at a time, launches the layer at the job's external ROM base address, and tags each `valid` feature-row output with owner, feature index and row for the downstream feature buffer. It retires the job on `image_calc_fin`. It sits between the layer top and the job sources (host/DMA sequencers).

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 16: external ROM base-address width, equal to `EXT_ADDR_WIDTH.
- FEAT_W, 3: width of the feature-index field.
- ROW_W, 3: width of the feature-row field.
- EXP_ROWS, 24: expected number of `valid` pulses per image (features × rows).
- GAP_CYC, 2: cycles `conv_enable` is held low between jobs.
- TIMEOUT_CYC, 4096: watchdog limit; used only with the watchdog macro.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester job request.
- req_base  in  NUM_REQ*ADDR_W  per-requester base address; requester 0 in the LSBs.
- req_ready  out  NUM_REQ  one-hot accept, combinational, asserted only in IDLE.
- done  out  NUM_REQ  one-cycle retire pulse to the owner.
- err  out  NUM_REQ  one-cycle error pulse to the owner; coincides with `done`.
- busy  out  1  high when the state is not IDLE.
- owner  out  $clog2(NUM_REQ)  current or last owner.
- conv_enable  out  1  layer enable, registered.
- conv_base_addr  out  ADDR_W  latched base of the current job.
- conv_valid  in  1  layer row-output strobe.
- conv_feature_idx  in  FEAT_W  layer feature index.
- conv_feature_row  in  ROW_W  layer feature row.
- conv_image_fin  in  1  layer end-of-image pulse.
- wr_en  out  1  tagged write strobe, registered.
- wr_owner  out  $clog2(NUM_REQ)  tag: job owner.
- wr_feat  out  FEAT_W  tag: feature index.
- wr_row  out  ROW_W  tag: feature row.

## Operation
- States and transitions:
  - IDLE: if any `req_valid`, grant to the winner → RUN.
  - RUN: on `conv_image_fin` → DRAIN; with the watchdog, on timeout → DRAIN.
  - DRAIN: lasts GAP_CYC cycles → DONE.
  - DONE: lasts 1 cycle → IDLE.
- Arbitration:
  - Round-robin; search starts at `last_grant`+1 mod NUM_REQ.
  - `last_grant` updates only on accept (`req_valid[g]&req_ready[g]`).
  - Withdrawn requests are never accepted.
- On accept: latch `req_base[g]` into `conv_base_addr`, set `owner`=g, clear `row_cnt`, set `conv_enable`=1.
- RUN:
  - Each `conv_valid` increments `row_cnt`, which saturates at 2^8-1.
  - Each `conv_valid` produces one `wr_en` tagged with `owner`, `conv_feature_idx` and `conv_feature_row`.
  - `conv_valid` outside RUN is ignored: no tag, no count.
- `conv_image_fin` and `conv_valid` in the same cycle: the row is counted and tagged, then the state goes to DRAIN.
- On the RUN→DRAIN edge `conv_enable` drops to 0. It stays low through DRAIN, DONE and IDLE.
- DONE: `done[owner]`=1. `err[owner]`=1 if `row_cnt`≠EXP_ROWS or the watchdog fired.
- A request from the retiring owner during DONE competes normally in the next IDLE cycle; it gets lowest priority.
- Reset, including mid-job: state IDLE; all outputs 0; `last_grant`=NUM_REQ-1, so requester 0 wins first; `conv_base_addr`=0; `row_cnt`=0.

## Timing
- Accept at edge T: `conv_enable`=1 from T+1.
- Tag latency is 1 cycle. `conv_valid` sampled at edge V gives `wr_en` high for the cycle after V, with tag fields registered alongside.
- `conv_image_fin` sampled at edge E:
  - `conv_enable`=0 from E+1.
  - DRAIN covers GAP_CYC cycles.
  - `done` is high for exactly one cycle, E+1+GAP_CYC.
  - IDLE follows; the next accept comes at the earliest at E+2+GAP_CYC.
- Minimum enable-low gap between jobs is GAP_CYC+2 cycles. The layer's controller therefore always sees an enable falling edge.
- `req_ready` is a pure function of `req_valid`, `last_grant` and the state; it is never high outside IDLE.

## Configuration
- CONV_SCHED_WATCHDOG_EN defined:
  - A 13-bit cycle counter runs in RUN; it clears on any `conv_valid`.
  - On reaching TIMEOUT_CYC: go to DRAIN, and assert `err` together with `done`.
- CONV_SCHED_WATCHDOG_EN undefined: no counter; RUN exits only on `conv_image_fin`; `err` reflects row-count mismatch only.

## Structure
- Shared package `conv_sched_pkg`:
  - state enum (`S_IDLE`, `S_RUN`, `S_DRAIN`, `S_DONE`);
  - default constants EXP_ROWS and GAP_CYC;
  - owner-id typedef.
- One sub-module, `rr_arbiter`: NUM_REQ-wide round-robin priority pick. Inputs are the request vector and `last_grant`; outputs are a one-hot grant and an encoded index. Combinational.

## Test plan
- Single job: req 2 with base 0x0400; fin after 24 `valid` pulses.
  - `conv_base_addr`=0x0400.
  - 24 `wr_en` pulses with `wr_owner`=2.
  - `done[2]` at E+3; `err`=0.
- Fairness: reqs 0..3 held high continuously → grant order 0,1,2,3,0; no requester is granted twice before all four are served.
- Row mismatch: fin after 23 `valid` pulses → `done[owner]` and `err[owner]` both pulse.
- Same-cycle event: `conv_valid` and `conv_image_fin` together on the 24th row → 24 tags; `err`=0.
- Reset mid-RUN (after 10 rows): `conv_enable`, `busy`, `wr_en` and `done` are 0 immediately. After release, requester 0 wins the first grant.
- Watchdog (macro on, TIMEOUT_CYC=64): no `valid` for 64 cycles → `conv_enable` drops; `done` and `err` pulse. With the macro off, the scheduler stays in RUN.
